seq_gen: RTL

- Serial pattern generator: the transmit-side counterpart of the team's serial sequence detector (seq_check).
- Emits a programmable bit pattern MSB-first, one bit per clock, repeated N times with an optional idle gap between repetitions.
- Used as the stimulus source feeding a detector's data_in, and as a general serial framing source.
- Start/busy/done handshake to a controlling block.

---
 rtl/seq_gen_if.sv | 35 +++
 rtl/seq_gen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_gen_if.sv
// Control and serial-output bundle of the seq_gen pattern generator.
// The master drives the request fields and the slave (seq_gen) drives the serial stream.
interface seq_gen_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 8,
  parameter int GAP_W = 4
);
  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pat_in;
  logic [LEN_W-1:0] pat_len;
  logic [REP_W-1:0] rep_num;
  logic [GAP_W-1:0] gap_cyc;

  logic data_out;
  logic data_vld;
  logic frame_sop;
  logic busy;
  logic done;
  logic err;

  // Handshake: start is taken only while busy=0. The cycle after an accepted start,
  // busy and data_vld rise. done pulses once after the last bit. err pulses once on a
  // rejected start. abort in any cycle returns the block to idle with no done.
  modport master (
    output start, abort, pat_in, pat_len, rep_num, gap_cyc,
    input  data_out, data_vld, frame_sop, busy, done, err
  );

  modport slave (
    input  start, abort, pat_in, pat_len, rep_num, gap_cyc,
    output data_out, data_vld, frame_sop, busy, done, err
  );
endinterface

// File: rtl/seq_gen.sv
// Serial pattern generator: emits pat_in MSB-first, repeated rep_num times with
// optional idle gaps, framed by a start/busy/done handshake.
module seq_gen #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 8,
  parameter int GAP_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  seq_gen_if.slave   bus,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] PAT_W_L = LEN_W'(PAT_W);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] sh_q, sh_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bit_q, bit_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;

  logic dout_q, dout_d;
  logic vld_q, vld_d;
  logic sop_q, sop_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic             len_ok;
  logic             reload;
  logic [LEN_W-1:0] shamt;
  logic [PAT_W-1:0] aligned;

  // Left-align the pattern so the first bit to send always sits in the MSB;
  // bits at or above pat_len fall off the top.
  assign shamt   = PAT_W_L - bus.pat_len;
  assign aligned = bus.pat_in << shamt;
  assign len_ok  = (bus.pat_len != '0) && (bus.pat_len <= PAT_W_L);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    sh_d    = sh_q;
    len_d   = len_q;
    bit_d   = bit_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    dout_d  = 1'b0;
    vld_d   = 1'b0;
    sop_d   = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    reload  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (len_ok) begin
            state_d = ST_SEND;
            pat_d   = aligned;
            sh_d    = aligned << 1;
            len_d   = bus.pat_len;
            bit_d   = bus.pat_len - LEN_W'(1);
            rep_d   = (bus.rep_num == '0) ? '0 : bus.rep_num - REP_W'(1);
            gap_d   = bus.gap_cyc;
            dout_d  = aligned[PAT_W-1];
            vld_d   = 1'b1;
            sop_d   = 1'b1;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        busy_d = 1'b1;
        if (bit_q != '0) begin
          bit_d  = bit_q - LEN_W'(1);
          sh_d   = sh_q << 1;
          dout_d = sh_q[PAT_W-1];
          vld_d  = 1'b1;
        end else if (rep_q != '0) begin
          rep_d = rep_q - REP_W'(1);
          if (gap_q == '0) begin
            reload = 1'b1;
          end else begin
            state_d = ST_GAP;
            gcnt_d  = gap_q;
          end
        end else begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end
      end
      ST_GAP: begin
        busy_d = 1'b1;
        if (gcnt_q == GAP_W'(1)) reload = 1'b1;
        else                      gcnt_d = gcnt_q - GAP_W'(1);
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Start of a new repetition: first bit comes straight from the saved pattern.
    if (reload) begin
      state_d = ST_SEND;
      sh_d    = pat_q << 1;
      bit_d   = len_q - LEN_W'(1);
      dout_d  = pat_q[PAT_W-1];
      vld_d   = 1'b1;
      sop_d   = 1'b1;
      busy_d  = 1'b1;
    end

    if (bus.abort) begin
      state_d = ST_IDLE;
      dout_d  = 1'b0;
      vld_d   = 1'b0;
      sop_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      sh_q    <= '0;
      len_q   <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      dout_q  <= 1'b0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      sh_q    <= sh_d;
      len_q   <= len_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
      sop_q   <= sop_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.data_out  = dout_q;
  assign bus.data_vld  = vld_q;
  assign bus.frame_sop = sop_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign dbg_state_o   = state_q;

endmodule
